dma_oam_controller: RTL and testbench



---
 rtl/dma_oam_controller_pkg.sv | 27 ++
 rtl/dma_oam_controller.sv | 110 +++++++++++
 tb/tb_dma_oam_controller.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/dma_oam_controller_pkg.sv
// Shared constants, state encoding and source-page helper for the OAM DMA sequencer.
package dma_oam_controller_pkg;

  localparam int unsigned DMA_BYTE_COUNT   = 160;
  localparam logic [15:0] DMA_OAM_BASE     = 16'hFE00;
  localparam logic [15:0] DMA_REG_ADDR_DEF = 16'hFF46;
  localparam logic [7:0]  ECHO_PAGE_FIRST  = 8'hE0;
  localparam logic [7:0]  ECHO_PAGE_OFFSET = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_e;

  // Echo RAM (E000-FDFF) aliases work RAM 0x2000 lower.
  function automatic logic [7:0] src_page(input logic [7:0] hi);
    if (hi >= ECHO_PAGE_FIRST) begin
      return hi - ECHO_PAGE_OFFSET;
    end else begin
      return hi;
    end
  endfunction

endpackage

// File: rtl/dma_oam_controller.sv
// OAM DMA sequencer: passes CPU traffic to the MMU while idle, and on a write to
// the DMA register takes the bus to copy one source page prefix into OAM.
module dma_oam_controller
  import dma_oam_controller_pkg::*;
#(
  parameter int unsigned BYTE_COUNT   = DMA_BYTE_COUNT,
  parameter logic [15:0] OAM_BASE     = DMA_OAM_BASE,
  parameter logic [15:0] DMA_REG_ADDR = DMA_REG_ADDR_DEF
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  output logic        oCpuStall,
  output logic [15:0] oMmuAddr,
  output logic [7:0]  oMmuData,
  output logic        oMmuWe,
  input  logic [7:0]  iMmuData,
  output logic        oDmaActive,
  output logic        oDmaDone
);

  localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

  dma_state_e r_state;
  dma_state_e w_state_nxt;
  logic [7:0] r_idx;
  logic [7:0] w_idx_nxt;
  logic [7:0] r_src_hi;
  logic [7:0] w_src_hi_nxt;
  logic [7:0] w_src_page;
  logic       w_trigger;

  assign w_src_page = src_page(r_src_hi);
  assign w_trigger  = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

  // State, byte index and latched source page.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state  <= ST_IDLE;
      r_idx    <= 8'd0;
      r_src_hi <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_src_hi <= w_src_hi_nxt;
    end
  end

  // Next-state logic and bus mux; pass-through is the default.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_src_hi_nxt = r_src_hi;
    oMmuAddr     = iCpuAddr;
    oMmuData     = iCpuData;
    oMmuWe       = iCpuWe;
    oCpuStall    = 1'b0;
    oDmaActive   = 1'b0;
    oDmaDone     = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        oDmaDone = (r_state == ST_DONE);
        if (w_trigger) begin
          w_src_hi_nxt = iCpuData;
          w_idx_nxt    = 8'd0;
          w_state_nxt  = ST_START;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_START: begin
        oMmuAddr    = {w_src_page, 8'h00};
        oMmuData    = 8'h00;
        oMmuWe      = 1'b0;
        oCpuStall   = 1'b1;
        oDmaActive  = 1'b1;
        w_state_nxt = ST_READ;
      end
      ST_READ: begin
        oMmuAddr    = {w_src_page, r_idx};
        oMmuData    = 8'h00;
        oMmuWe      = 1'b0;
        oCpuStall   = 1'b1;
        oDmaActive  = 1'b1;
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        oMmuAddr   = OAM_BASE + {8'h00, r_idx};
        oMmuData   = iMmuData;
        // A reset arriving during the write cycle must not land one more byte.
        oMmuWe     = ~iReset;
        oCpuStall  = 1'b1;
        oDmaActive = 1'b1;
        w_idx_nxt  = r_idx + 8'd1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_oam_controller.sv
// Directed bench for dma_oam_controller with a behavioural MMU (registered reads, OAM store).
module tb_dma_oam_controller;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic [7:0]  iCpuData;
  logic        iCpuWe;
  logic        oCpuStall;
  logic [15:0] oMmuAddr;
  logic [7:0]  oMmuData;
  logic        oMmuWe;
  logic [7:0]  iMmuData;
  logic        oDmaActive;
  logic        oDmaDone;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [7:0] oam [0:255];

  dma_oam_controller dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iCpuAddr  (iCpuAddr),
    .iCpuData  (iCpuData),
    .iCpuWe    (iCpuWe),
    .oCpuStall (oCpuStall),
    .oMmuAddr  (oMmuAddr),
    .oMmuData  (oMmuData),
    .oMmuWe    (oMmuWe),
    .iMmuData  (iMmuData),
    .oDmaActive(oDmaActive),
    .oDmaDone  (oDmaDone)
  );

  always #5 iClock = ~iClock;

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'h5A;
      8'hC1:   return a[7:0] ^ 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  // MMU model: registered read data, OAM page storage, write counter.
  always @(posedge iClock) begin
    iMmuData <= src_byte(oMmuAddr);
    if (oMmuWe) begin
      wr_cnt <= wr_cnt + 1;
      if (oMmuAddr[15:8] == 8'hFE) oam[oMmuAddr[7:0]] <= oMmuData;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_dma(input logic [7:0] v);
    @(negedge iClock);
    iCpuAddr = 16'hFF46;
    iCpuData = v;
    iCpuWe   = 1'b1;
    @(posedge iClock);
    #1;
    iCpuWe   = 1'b0;
    iCpuAddr = 16'h0000;
  endtask

  // Called #1 after the trigger edge; returns at the falling edge of the DONE cycle.
  task automatic wait_done(input logic [7:0] pg);
    int cyc;
    int stalls;
    int w0;
    cyc    = 0;
    stalls = 0;
    w0     = wr_cnt;
    for (int k = 0; k < 400; k++) begin
      @(negedge iClock);
      cyc++;
      if (oCpuStall) stalls++;
      if (cyc == 1) begin
        check("start_addr", 32'(oMmuAddr), 32'({pg, 8'h00}));
        check("start_we", 32'(oMmuWe), 32'd0);
        check("start_active", 32'(oDmaActive), 32'd1);
      end
      if (cyc == 2) check("read0_addr", 32'(oMmuAddr), 32'({pg, 8'h00}));
      if (cyc == 3) begin
        check("write0_addr", 32'(oMmuAddr), 32'h0000FE00);
        check("write0_we", 32'(oMmuWe), 32'd1);
        check("write0_data", 32'(oMmuData), 32'(src_byte({pg, 8'h00})));
      end
      if (oDmaDone) break;
    end
    check("done_cycle", 32'(cyc), 32'd322);
    check("stall_len", 32'(stalls), 32'd321);
    check("dma_writes", 32'(wr_cnt - w0), 32'd160);
    check("done_stall", 32'(oCpuStall), 32'd0);
  endtask

  task automatic check_oam(input string tag, input logic [7:0] pg);
    int bad;
    bad = 0;
    for (int i = 0; i < 160; i++) begin
      if (oam[i] !== src_byte({pg, 8'(i)})) bad++;
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    int w0;
    int dn;
    iReset   = 1'b1;
    iCpuAddr = 16'h0000;
    iCpuData = 8'h00;
    iCpuWe   = 1'b0;
    repeat (2) @(negedge iClock);

    iCpuAddr = 16'h1234;
    iCpuWe   = 1'b1;
    #1;
    check("rst_stall", 32'(oCpuStall), 32'd0);
    check("rst_active", 32'(oDmaActive), 32'd0);
    check("rst_done", 32'(oDmaDone), 32'd0);
    check("rst_we_pass", 32'(oMmuWe), 32'd1);

    iCpuAddr = 16'hFF46;
    iCpuData = 8'hC0;
    @(negedge iClock);
    check("rst_ff46_ignored", 32'(oDmaActive), 32'd0);
    iReset   = 1'b0;
    iCpuWe   = 1'b0;
    iCpuAddr = 16'h0000;
    @(negedge iClock);

    iCpuAddr = 16'hC000;
    iCpuData = 8'h3C;
    iCpuWe   = 1'b1;
    #1;
    check("pt_wr_addr", 32'(oMmuAddr), 32'h0000C000);
    check("pt_wr_data", 32'(oMmuData), 32'h0000003C);
    check("pt_wr_we", 32'(oMmuWe), 32'd1);
    check("pt_wr_stall", 32'(oCpuStall), 32'd0);
    @(negedge iClock);
    iCpuAddr = 16'h8000;
    iCpuData = 8'h11;
    iCpuWe   = 1'b0;
    #1;
    check("pt_rd_addr", 32'(oMmuAddr), 32'h00008000);
    check("pt_rd_we", 32'(oMmuWe), 32'd0);
    check("pt_rd_stall", 32'(oCpuStall), 32'd0);
    @(negedge iClock);
    check("pt_no_start", 32'(oDmaActive), 32'd0);

    start_dma(8'hC0);
    wait_done(8'hC0);
    @(negedge iClock);
    check("after_done_pulse", 32'(oDmaDone), 32'd0);
    check("after_done_active", 32'(oDmaActive), 32'd0);
    check_oam("oam_c0", 8'hC0);

    start_dma(8'hE1);
    wait_done(8'hC1);
    check_oam("oam_mirror_c1", 8'hC1);

    start_dma(8'hC0);
    w0 = wr_cnt;
    repeat (83) @(negedge iClock);
    check("rst_mid_addr", 32'(oMmuAddr), 32'h0000FE28);
    check("rst_mid_writes", 32'(wr_cnt - w0), 32'd40);
    iReset = 1'b1;
    @(negedge iClock);
    iReset = 1'b0;
    check("rst_mid_active", 32'(oDmaActive), 32'd0);
    dn = 0;
    repeat (400) begin
      @(negedge iClock);
      if (oDmaDone) dn++;
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);
    check("rst_mid_no_more_wr", 32'(wr_cnt - w0), 32'd40);
    check("rst_mid_oam39", 32'(oam[39]), 32'(8'd39 ^ 8'h5A));
    check("rst_mid_oam40", 32'(oam[40]), 32'(8'd40 ^ 8'hA5));
    check("rst_mid_oam159", 32'(oam[159]), 32'(8'd159 ^ 8'hA5));

    start_dma(8'hC1);
    wait_done(8'hC1);
    iCpuAddr = 16'hFF46;
    iCpuData = 8'hC0;
    iCpuWe   = 1'b1;
    #1;
    check("b2b_done_pass_we", 32'(oMmuWe), 32'd1);
    check("b2b_done_pass_addr", 32'(oMmuAddr), 32'h0000FF46);
    @(posedge iClock);
    #1;
    iCpuWe   = 1'b0;
    iCpuAddr = 16'h0000;
    wait_done(8'hC0);
    check_oam("oam_b2b_c0", 8'hC0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
